pd_packet_serializer: RTL



---
 rtl/pd_pkg.sv | 21 ++
 rtl/pd_crc16.sv | 28 ++
 rtl/pd_packet_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared types and constants for the packet-data serializer
package pd_pkg;

    localparam int          PD_WORD_W   = 16;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic        SERIAL_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } pd_ser_state_t;

    // One MSB-first CRC step: feedback is the outgoing CRC MSB xor the line bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/pd_crc16.sv
// rtl/pd_crc16.sv - bit-serial CRC-16 register, no reflection, no final xor
module pd_crc16
    import pd_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic [15:0] init_val,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= 16'h0000;
        end else if (init) begin
            r_crc <= init_val;
        end else if (shift_en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/pd_packet_serializer.sv
// rtl/pd_packet_serializer.sv - pulls a frame word by word and sends it MSB-first
// with a start bit and trailing CRC-16 on a single serial line
module pd_packet_serializer
    import pd_pkg::*;
#(
    parameter int          NUM_WORDS  = 20,
    parameter int          BIT_PERIOD = 8,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [PD_WORD_W-1:0] tx_data,
    output logic                 read_enable,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          crc_out
);

    localparam int                 CNT_W     = $clog2(BIT_PERIOD);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [4:0]         LAST_WORD = 5'(NUM_WORDS - 1);

    pd_ser_state_t    r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_bit_idx;
    logic [4:0]       r_word_cnt;
    logic [15:0]      r_shift;
    logic [15:0]      r_crc_out;

    logic             w_period_end;
    logic             w_bit_end;
    logic             w_last_word;
    logic             w_crc_init;
    logic             w_crc_shift;
    logic [15:0]      w_crc;
    logic             w_serial;

    assign w_period_end = (r_bit_cnt == LAST_CNT);
    assign w_bit_end    = w_period_end && (r_bit_idx == 4'd15);
    assign w_last_word  = (r_word_cnt == LAST_WORD);
    assign w_crc_init   = (r_state == ST_IDLE) && start;
    assign w_crc_shift  = (r_state == ST_DATA) && w_period_end;

    pd_crc16 u_crc16 (
        .clk      (clk),
        .n_rst    (n_rst),
        .init     (w_crc_init),
        .init_val (CRC_INIT),
        .shift_en (w_crc_shift),
        .bit_in   (r_shift[15]),
        .crc      (w_crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_crc_out  <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SOF;
                        r_bit_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_SOF: begin
                    if (w_period_end) begin
                        r_state    <= ST_DATA;
                        r_bit_cnt  <= '0;
                        r_shift    <= tx_data;
                        r_word_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_period_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                        // Next word loads on the same edge as the last shift: no gap bit.
                        if (r_bit_idx == 4'd15) begin
                            if (w_last_word) begin
                                r_state <= ST_CRC;
                            end else begin
                                r_shift    <= tx_data;
                                r_word_cnt <= r_word_cnt + 5'd1;
                            end
                        end else begin
                            r_shift <= {r_shift[14:0], 1'b0};
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    if (w_period_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd15) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_crc_out <= w_crc;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // CRC is frozen in ST_CRC, so its bits are indexed directly rather than shifted.
    always_comb begin
        w_serial = SERIAL_IDLE;
        case (r_state)
            ST_SOF:  w_serial = 1'b0;
            ST_DATA: w_serial = r_shift[15];
            ST_CRC:  w_serial = w_crc[~r_bit_idx];
            default: w_serial = SERIAL_IDLE;
        endcase
    end

    assign read_enable = ((r_state == ST_SOF) && w_period_end) ||
                         ((r_state == ST_DATA) && w_bit_end && !w_last_word);
    assign serial_out  = w_serial;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign crc_out     = r_crc_out;

endmodule
